// File: rtl/bmu_issue_scheduler_if.sv
// rtl/bmu_issue_scheduler_if.sv - issue request and writeback handshake bundle for the BMU scheduler
interface bmu_issue_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int UOP_WIDTH  = 3
);
    logic [1:0]                     req_valid_i;
    logic [1:0]                     req_ready_o;
    logic [1:0][DATA_WIDTH-1:0]     req_operand_A_i;
    logic [1:0][DATA_WIDTH-1:0]     req_operand_B_i;
    logic [1:0][UOP_WIDTH-1:0]      req_operation_i;
    logic [1:0][TAG_WIDTH-1:0]      req_tag_i;
    logic                           wb_valid_o;
    logic                           wb_ready_i;
    logic [DATA_WIDTH-1:0]          wb_result_o;
    logic [TAG_WIDTH-1:0]           wb_tag_o;
    logic                           wb_port_o;

    modport slave (
        input  req_valid_i, req_operand_A_i, req_operand_B_i, req_operation_i, req_tag_i, wb_ready_i,
        output req_ready_o, wb_valid_o, wb_result_o, wb_tag_o, wb_port_o
    );

    modport master (
        output req_valid_i, req_operand_A_i, req_operand_B_i, req_operation_i, req_tag_i, wb_ready_i,
        input  req_ready_o, wb_valid_o, wb_result_o, wb_tag_o, wb_port_o
    );
endinterface

// File: rtl/bmu_issue_scheduler.sv
// rtl/bmu_issue_scheduler.sv - round-robin issue into the single-cycle BMU with clock gating and credited result FIFO
module bmu_issue_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int UOP_WIDTH  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    bmu_issue_scheduler_if.slave    bus,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   bmu_operand_A_o,
    output logic [DATA_WIDTH-1:0]   bmu_operand_B_o,
    output logic [UOP_WIDTH-1:0]    bmu_operation_o,
    output logic                    bmu_data_valid_o,
    output logic                    bmu_clk_en_o,
    input  logic [DATA_WIDTH-1:0]   bmu_result_i,
    input  logic                    bmu_data_valid_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic                  prio_q, prio_d;
    logic                  inflight_q, inflight_d;
    logic                  live_q, live_d;
    logic [TAG_WIDTH-1:0]  inf_tag_q, inf_tag_d;
    logic                  inf_port_q, inf_port_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [DATA_WIDTH-1:0] res_mem_q  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem_q  [FIFO_DEPTH];
    logic                  port_mem_q [FIFO_DEPTH];

    logic [1:0]            grant;
    logic                  fire, sel, pop, push, wb_valid, can_issue;
    logic [CW-1:0]         occupancy;

    always_comb begin
        wb_valid  = (count_q != '0);
        pop       = wb_valid & bus.wb_ready_i;
        push      = inflight_q & live_q & bmu_data_valid_i & ~flush_i;
        // pop implies count_q >= 1, so the subtraction never wraps
        occupancy = count_q + CW'(live_q) - CW'(pop);
        can_issue = rst_n_i & ~flush_i & (occupancy < DEPTH_C);

        grant = '0;
        if (can_issue) begin
            if (bus.req_valid_i[prio_q]) begin
                grant[prio_q] = 1'b1;
            end else if (bus.req_valid_i[~prio_q]) begin
                grant[~prio_q] = 1'b1;
            end
        end
        fire = |grant;
        sel  = grant[1];

        prio_d     = fire ? ~sel : prio_q;
        inflight_d = fire;
        live_d     = fire;
        inf_tag_d  = fire ? bus.req_tag_i[sel] : inf_tag_q;
        inf_port_d = fire ? sel : inf_port_q;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q     <= 1'b0;
            inflight_q <= 1'b0;
            live_q     <= 1'b0;
            inf_tag_q  <= '0;
            inf_port_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
            live_q     <= live_d;
            inf_tag_q  <= inf_tag_d;
            inf_port_q <= inf_port_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: wb data is masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            res_mem_q[wr_ptr_q]  <= bmu_result_i;
            tag_mem_q[wr_ptr_q]  <= inf_tag_q;
            port_mem_q[wr_ptr_q] <= inf_port_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (!(push && count_q == DEPTH_C));
        end
    end

    assign bus.req_ready_o  = grant;
    assign bmu_operand_A_o  = bus.req_operand_A_i[sel];
    assign bmu_operand_B_o  = bus.req_operand_B_i[sel];
    assign bmu_operation_o  = bus.req_operation_i[sel];
    assign bmu_data_valid_o = fire;
    assign bmu_clk_en_o     = fire | inflight_q;

    assign bus.wb_valid_o   = wb_valid;
    assign bus.wb_result_o  = wb_valid ? res_mem_q[rd_ptr_q]  : '0;
    assign bus.wb_tag_o     = wb_valid ? tag_mem_q[rd_ptr_q]  : '0;
    assign bus.wb_port_o    = wb_valid ? port_mem_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_bmu_issue_scheduler.sv
// tb/tb_bmu_issue_scheduler.sv - self-checking bench for bmu_issue_scheduler with a queue-based reference model
module tb_bmu_issue_scheduler;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int D  = 2;
    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2, OP_ANDN = 3'd3,
                           OP_ORN = 3'd4, OP_XNOR = 3'd5, OP_MINU = 3'd6, OP_MAXU = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] bmu_a, bmu_b, bmu_r;
    logic [2:0]    bmu_op;
    logic          bmu_dv, bmu_clk_en, bmu_v;

    bmu_issue_scheduler_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .UOP_WIDTH(3)) bus ();

    bmu_issue_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(D), .UOP_WIDTH(3)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .bus              (bus),
        .flush_i          (flush),
        .bmu_operand_A_o  (bmu_a),
        .bmu_operand_B_o  (bmu_b),
        .bmu_operation_o  (bmu_op),
        .bmu_data_valid_o (bmu_dv),
        .bmu_clk_en_o     (bmu_clk_en),
        .bmu_result_i     (bmu_r),
        .bmu_data_valid_i (bmu_v)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bmu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ANDN: return a & ~b;
            OP_ORN:  return a | ~b;
            OP_XNOR: return ~(a ^ b);
            OP_MINU: return (a < b) ? a : b;
            default: return (a > b) ? a : b;
        endcase
    endfunction

    // Single-cycle BMU: clock-gated valid/result register sharing the scheduler reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmu_v <= 1'b0;
            bmu_r <= '0;
        end else if (bmu_clk_en) begin
            bmu_v <= bmu_dv;
            bmu_r <= bmu_f(bmu_op, bmu_a, bmu_b);
        end
    end

    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        logic          port;
        int            rdy;
    } ent_t;

    ent_t       q[$];
    int         prio_m = 0;
    bit         fired_prev = 0;
    int         cyc = 0;
    logic [1:0] p_grant;
    bit         p_fire, p_pop, p_wbv;
    int         checks = 0;
    int         errors = 0;

    task automatic model_reset();
        q.delete();
        prio_m     = 0;
        fired_prev = 0;
    endtask

    task automatic drive(input logic [1:0] v, input logic fl, input logic rdy);
        bus.req_valid_i = v;
        flush           = fl;
        bus.wb_ready_i  = rdy;
        for (int p = 0; p < 2; p++) begin
            bus.req_operand_A_i[p] = $urandom;
            bus.req_operand_B_i[p] = $urandom;
            bus.req_operation_i[p] = 3'($urandom_range(0, 7));
            bus.req_tag_i[p]       = 4'($urandom);
        end
    endtask

    // Outstanding results = everything issued but not yet written back or flushed
    task automatic settle();
        bit can;
        int sz;
        #1;
        sz      = q.size();
        p_wbv   = (sz > 0) && (q[0].rdy <= cyc);
        p_pop   = p_wbv && bus.wb_ready_i;
        can     = rst_n && !flush && ((sz - int'(p_pop)) < D);
        p_grant = 2'b00;
        if (can) begin
            if (bus.req_valid_i[prio_m]) p_grant[prio_m] = 1'b1;
            else if (bus.req_valid_i[1-prio_m]) p_grant[1-prio_m] = 1'b1;
        end
        p_fire = |p_grant;
    endtask

    task automatic commit();
        ent_t e;
        int   g;
        if (p_pop) void'(q.pop_front());
        if (flush) q.delete();
        if (p_fire) begin
            g      = int'(p_grant[1]);
            e.res  = bmu_f(bus.req_operation_i[g], bus.req_operand_A_i[g], bus.req_operand_B_i[g]);
            e.tag  = bus.req_tag_i[g];
            e.port = p_grant[1];
            e.rdy  = cyc + 2;
            q.push_back(e);
            prio_m = 1 - g;
        end
        fired_prev = p_fire;
        cyc++;
    endtask

    task automatic step(input logic [1:0] v, input logic fl, input logic rdy);
        @(negedge clk);
        drive(v, fl, rdy);
        settle();
        commit();
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 1'b0, 1'b1);
        #3;
        checks++;
        if ({bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b dv=%b clk_en=%b wbv=%b res=%h tag=%h port=%b, expected all 0",
                     bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o);
        end
        model_reset();
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_andn();
        @(negedge clk);
        drive(2'b01, 1'b0, 1'b1);
        bus.req_operand_A_i[0] = 32'hF0F0_F0F0;
        bus.req_operand_B_i[0] = 32'hFF00_FF00;
        bus.req_operation_i[0] = OP_ANDN;
        bus.req_tag_i[0]       = 4'd3;
        settle();
        checks++;
        if ({bus.req_ready_o, bmu_dv, bmu_clk_en} !== 4'b0111) begin
            errors++;
            $display("FAIL andn_issue: got ready=%b dv=%b clk_en=%b, expected 01 1 1", bus.req_ready_o, bmu_dv, bmu_clk_en);
        end
        commit();
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1);
        settle();
        checks++;
        if ({bmu_clk_en, bus.wb_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL andn_cycle1: got clk_en=%b wbv=%b, expected 1 0", bmu_clk_en, bus.wb_valid_o);
        end
        commit();
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1);
        settle();
        checks++;
        if ({bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !== {1'b0, 1'b1, 32'h00F0_00F0, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL andn_writeback: got clk_en=%b wbv=%b res=%h tag=%0d port=%b, expected 0 1 00f000f0 3 0",
                     bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o);
        end
        commit();
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1);
        settle();
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL andn_popped: got wbv=%b, expected 0", bus.wb_valid_o);
        end
        commit();
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        prev = 2'b00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(2'b11, 1'b0, 1'b1);
            settle();
            checks++;
            if ({bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o} !== {p_grant, p_fire, p_fire | fired_prev, p_wbv}) begin
                errors++;
                $display("FAIL rr_ctrl cyc %0d: got ready=%b dv=%b en=%b wbv=%b, expected ready=%b dv=%b en=%b wbv=%b",
                         cyc, bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, p_grant, p_fire, p_fire | fired_prev, p_wbv);
            end
            if (i > 0) begin
                checks++;
                if (bus.req_ready_o !== {prev[0], prev[1]}) begin
                    errors++;
                    $display("FAIL rr_alternate cyc %0d: got %b, expected %b", cyc, bus.req_ready_o, {prev[0], prev[1]});
                end
            end
            if (p_wbv) begin
                checks++;
                if ({bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !== {q[0].res, q[0].tag, q[0].port}) begin
                    errors++;
                    $display("FAIL rr_head cyc %0d: got %h/%h/%b, expected %h/%h/%b", cyc,
                             bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o, q[0].res, q[0].tag, q[0].port);
                end
            end
            prev = bus.req_ready_o;
            commit();
        end
    endtask

    task automatic test_backpressure();
        int fires;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(2'b11, 1'b0, 1'b0);
            settle();
            checks++;
            if ({bus.req_ready_o, bmu_dv, bus.wb_valid_o} !== {p_grant, p_fire, p_wbv}) begin
                errors++;
                $display("FAIL bp_ctrl cyc %0d: got ready=%b dv=%b wbv=%b, expected ready=%b dv=%b wbv=%b",
                         cyc, bus.req_ready_o, bmu_dv, bus.wb_valid_o, p_grant, p_fire, p_wbv);
            end
            fires += int'(bmu_dv);
            commit();
        end
        checks++;
        if (fires != D) begin
            errors++;
            $display("FAIL bp_issue_count: got %0d issues, expected %0d", fires, D);
        end
        @(negedge clk);
        drive(2'b11, 1'b0, 1'b1);
        settle();
        checks++;
        if ({bus.wb_valid_o, bmu_dv, |bus.req_ready_o} !== 3'b111) begin
            errors++;
            $display("FAIL bp_resume: got wbv=%b dv=%b ready=%b, expected issue on first pop", bus.wb_valid_o, bmu_dv, bus.req_ready_o);
        end
        commit();
    endtask

    task automatic test_flush();
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        drive(2'b11, 1'b1, 1'b0);
        settle();
        checks++;
        if ({bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o} !== 5'b00011) begin
            errors++;
            $display("FAIL flush_cycle: got ready=%b dv=%b en=%b wbv=%b, expected 00 0 1 1",
                     bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o);
        end
        commit();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b00, 1'b0, 1'b1);
            settle();
            checks++;
            if ({bmu_clk_en, bus.wb_valid_o} !== 2'b00) begin
                errors++;
                $display("FAIL flush_after %0d: got en=%b wbv=%b, expected 0 0", i, bmu_clk_en, bus.wb_valid_o);
            end
            commit();
        end
    endtask

    task automatic test_push_pop_wrap();
        int pops;
        pops = 0;
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(2'b11, 1'b0, 1'b1);
            settle();
            checks++;
            if ({bus.req_ready_o, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !==
                {p_grant, p_wbv, q[0].res, q[0].tag, q[0].port}) begin
                errors++;
                $display("FAIL wrap cyc %0d: got ready=%b wbv=%b %h/%h/%b, expected ready=%b wbv=%b %h/%h/%b", cyc,
                         bus.req_ready_o, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o,
                         p_grant, p_wbv, q[0].res, q[0].tag, q[0].port);
            end
            pops += int'(bus.wb_valid_o);
            commit();
        end
        checks++;
        if (pops != 12) begin
            errors++;
            $display("FAIL wrap_pops: got %0d pops, expected 12", pops);
        end
    endtask

    task automatic test_async_reset();
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        @(negedge clk);
        drive(2'b11, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b dv=%b en=%b wbv=%b res=%h tag=%h port=%b, expected all 0",
                     bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o);
        end
        model_reset();
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(2'b11, 1'b0, 1'b1);
        settle();
        checks++;
        if ({bus.req_ready_o, bus.wb_valid_o} !== 3'b010) begin
            errors++;
            $display("FAIL post_reset_prio: got ready=%b wbv=%b, expected 01 0", bus.req_ready_o, bus.wb_valid_o);
        end
        commit();
        @(negedge clk);
        drive(2'b10, 1'b0, 1'b1);
        settle();
        checks++;
        if (bus.req_ready_o !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_port1: got ready=%b, expected 10", bus.req_ready_o);
        end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive(2'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            settle();
            checks++;
            if ({bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o} !== {p_grant, p_fire, p_fire | fired_prev, p_wbv}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got ready=%b dv=%b en=%b wbv=%b, expected ready=%b dv=%b en=%b wbv=%b",
                         cyc, bus.req_ready_o, bmu_dv, bmu_clk_en, bus.wb_valid_o, p_grant, p_fire, p_fire | fired_prev, p_wbv);
            end
            if (p_wbv) begin
                checks++;
                if ({bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o} !== {q[0].res, q[0].tag, q[0].port}) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d: got %h/%h/%b, expected %h/%h/%b", cyc,
                             bus.wb_result_o, bus.wb_tag_o, bus.wb_port_o, q[0].res, q[0].tag, q[0].port);
                end
            end
            commit();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_andn();
        test_round_robin();
        drain();
        test_backpressure();
        drain();
        test_flush();
        drain();
        test_push_pop_wrap();
        drain();
        test_async_reset();
        drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
